pid_seq: RTL and testbench



---
 rtl/pid_seq_if.sv | 23 ++
 rtl/pid_seq.sv | 148 ++++++++++++++
 tb/tb_pid_seq.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pid_seq_if.sv
// Pitch-in / motor-drive-out bundle for the balance PID sequencer.
// The sequencer takes the slave side; the sample source and drive consumer take master.
interface pid_seq_if;
    logic               vld;
    logic signed [15:0] ptch;
    logic               pwr_up;
    logic               rider_off;
    logic               busy;
    logic [10:0]        mtr_duty;
    logic               rev;
    logic               duty_vld;
    logic               drop;

    modport master (
        output vld, ptch, pwr_up, rider_off,
        input  busy, mtr_duty, rev, duty_vld, drop
    );

    modport slave (
        input  vld, ptch, pwr_up, rider_off,
        output busy, mtr_duty, rev, duty_vld, drop
    );
endinterface

// File: rtl/pid_seq.sv
// Balance PID sequencer: pitch sample -> saturated err, integral, derivative, duty/dir.
// Latency: duty_vld 5 cycles after accepted vld; no backpressure, vld while busy is dropped.
module pid_seq #(
    parameter int          D_QUEUE_DEPTH = 2,
    parameter logic [10:0] MIN_DUTY      = 11'h3D4
) (
    input logic        clk,
    input logic        rst,
    pid_seq_if.slave   bus
);
    typedef enum logic [2:0] {IDLE, SAT, INTEG, DERIV, CALC} state_t;

    state_t             state_q, state_d;
    logic signed [15:0] ptch_q, ptch_d;
    logic signed [9:0]  err_q, err_d;
    logic signed [17:0] integ_q, integ_d;
    logic signed [9:0]  queue_q [D_QUEUE_DEPTH];
    logic signed [9:0]  queue_d [D_QUEUE_DEPTH];
    logic signed [6:0]  diff_q, diff_d;
    logic [10:0]        mtr_duty_q, mtr_duty_d;
    logic               rev_q, rev_d;
    logic               duty_vld_q, duty_vld_d;
    logic               drop_q, drop_d;

    // Datapath helpers for each stage
    logic signed [9:0]  sat_err;
    logic signed [18:0] integ_sum;
    logic signed [17:0] integ_sat;
    logic signed [9:0]  old_err;
    logic signed [10:0] diff11;
    logic signed [6:0]  diff_sat;
    logic signed [12:0] diff13, d_term, err13, p_term, ei13, i_term, pid;
    logic [12:0]        abs_pid, duty13;
    logic [10:0]        duty_sat;

    assign sat_err = (ptch_q > 16'sd511)  ? 10'sd511 :
                     (ptch_q < -16'sd512) ? -10'sd512 : ptch_q[9:0];

    assign integ_sum = {integ_q[17], integ_q} + {{9{err_q[9]}}, err_q};
    // A sign mismatch between the top two sum bits is a signed overflow
    assign integ_sat = (integ_sum[18] != integ_sum[17]) ?
                       (integ_sum[18] ? 18'sh20000 : 18'sh1FFFF) : integ_sum[17:0];

    assign old_err  = bus.rider_off ? 10'sd0 : queue_q[D_QUEUE_DEPTH-1];
    assign diff11   = {err_q[9], err_q} - {old_err[9], old_err};
    assign diff_sat = (diff11 > 11'sd63)  ? 7'sd63 :
                      (diff11 < -11'sd63) ? -7'sd63 : diff11[6:0];

    assign diff13 = {{6{diff_q[6]}}, diff_q};
    assign d_term = diff13 * 13'sd9;
    assign err13  = {{3{err_q[9]}}, err_q};
    assign p_term = (err13 >>> 1) + (err13 >>> 2);
    assign ei13   = {{3{integ_q[17]}}, integ_q[17:8]};
    assign i_term = ei13 >>> 1;
    assign pid    = d_term + p_term + i_term;
    assign abs_pid  = pid[12] ? 13'(-pid) : 13'(pid);
    assign duty13   = {2'b00, MIN_DUTY} + abs_pid;
    assign duty_sat = (duty13[12:11] != 2'b00) ? 11'h7FF : duty13[10:0];

    always_comb begin
        state_d    = state_q;
        ptch_d     = ptch_q;
        err_d      = err_q;
        integ_d    = integ_q;
        queue_d    = queue_q;
        diff_d     = diff_q;
        mtr_duty_d = mtr_duty_q;
        rev_d      = rev_q;
        duty_vld_d = 1'b0;
        drop_d     = 1'b0;

        if (!bus.pwr_up) begin
            state_d    = IDLE;
            integ_d    = '0;
            for (int i = 0; i < D_QUEUE_DEPTH; i++) queue_d[i] = '0;
            mtr_duty_d = '0;
            rev_d      = 1'b0;
        end else begin
            if (bus.vld && state_q != IDLE) drop_d = 1'b1;
            case (state_q)
                IDLE: begin
                    if (bus.vld) begin
                        ptch_d  = bus.ptch;
                        state_d = SAT;
                    end
                end
                SAT: begin
                    err_d   = sat_err;
                    state_d = INTEG;
                end
                INTEG: begin
                    integ_d = integ_sat;
                    state_d = DERIV;
                end
                DERIV: begin
                    diff_d = diff_sat;
                    for (int i = D_QUEUE_DEPTH - 1; i > 0; i--) queue_d[i] = queue_q[i-1];
                    queue_d[0] = err_q;
                    state_d    = CALC;
                end
                CALC: begin
                    mtr_duty_d = duty_sat;
                    rev_d      = pid[12];
                    duty_vld_d = 1'b1;
                    state_d    = IDLE;
                end
                default: state_d = IDLE;
            endcase
            // Rider-off clearing overrides any stage update this cycle
            if (bus.rider_off) begin
                integ_d = '0;
                for (int i = 0; i < D_QUEUE_DEPTH; i++) queue_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptch_q     <= '0;
            err_q      <= '0;
            integ_q    <= '0;
            for (int i = 0; i < D_QUEUE_DEPTH; i++) queue_q[i] <= '0;
            diff_q     <= '0;
            mtr_duty_q <= '0;
            rev_q      <= 1'b0;
            duty_vld_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptch_q     <= ptch_d;
            err_q      <= err_d;
            integ_q    <= integ_d;
            queue_q    <= queue_d;
            diff_q     <= diff_d;
            mtr_duty_q <= mtr_duty_d;
            rev_q      <= rev_d;
            duty_vld_q <= duty_vld_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.mtr_duty = mtr_duty_q;
    assign bus.rev      = rev_q;
    assign bus.duty_vld = duty_vld_q;
    assign bus.drop     = drop_q;
endmodule

// File: tb/tb_pid_seq.sv
// Directed bench for pid_seq: hand-computed duty/direction per pitch sample,
// plus drop, abort-by-reset, power-down and rider-off behaviour.
module tb_pid_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pid_seq_if bus ();

    pid_seq #(.D_QUEUE_DEPTH(2), .MIN_DUTY(11'h3D4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Pulse one sample and wait (bounded) for duty_vld; leaves us at that negedge
    task automatic run_sample(input logic signed [15:0] p, input string tag);
        int lat;
        @(negedge clk);
        bus.vld  = 1'b1;
        bus.ptch = p;
        @(negedge clk);
        bus.vld  = 1'b0;
        lat = 1;
        while (bus.duty_vld !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, lat, 5);
    endtask

    initial begin
        int n_vld;
        int seen_duty;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.vld       = 1'b0;
        bus.ptch      = '0;
        bus.pwr_up    = 1'b1;
        bus.rider_off = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_duty", bus.mtr_duty, 0);
        chk("rst_rev", bus.rev, 0);
        chk("rst_dvld", bus.duty_vld, 0);
        chk("rst_drop", bus.drop, 0);
        rst = 1'b0;

        // err=100: D=567 P=75 I=0 -> 980+642
        run_sample(16'sd100, "p100");
        chk("p100_duty", bus.mtr_duty, 1622);
        chk("p100_rev", bus.rev, 0);
        @(negedge clk);
        chk("p100_dvld_pulse", bus.duty_vld, 0);
        chk("p100_idle", bus.busy, 0);

        // err=-512: D=-567 P=-384 I=-1 -> PID=-952
        do_reset();
        run_sample(-16'sd2000, "m2000");
        chk("m2000_duty", bus.mtr_duty, 1932);
        chk("m2000_rev", bus.rev, 1);

        // Second vld two cycles into a sequence is dropped
        do_reset();
        @(negedge clk);
        bus.vld = 1'b1; bus.ptch = 16'sd100;
        @(negedge clk);
        bus.vld = 1'b0;
        @(negedge clk);
        bus.vld = 1'b1; bus.ptch = -16'sd2000;
        @(negedge clk);
        bus.vld = 1'b0;
        chk("drop_hi", bus.drop, 1);
        @(negedge clk);
        chk("drop_lo", bus.drop, 0);
        n_vld = 0; seen_duty = -1;
        repeat (10) begin
            if (bus.duty_vld === 1'b1) begin
                n_vld++;
                seen_duty = bus.mtr_duty;
            end
            @(negedge clk);
        end
        chk("drop_nvld", n_vld, 1);
        chk("drop_duty", seen_duty, 1622);

        // Reset in DERIV aborts; queue/integrator must be clean afterwards
        do_reset();
        run_sample(16'sd100, "ab1");
        run_sample(16'sd100, "ab2");
        chk("ab2_duty", bus.mtr_duty, 1622);
        @(negedge clk);
        bus.vld = 1'b1; bus.ptch = 16'sd100;
        @(negedge clk);
        bus.vld = 1'b0;
        repeat (2) @(negedge clk);
        chk("ab_busy_deriv", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vld = 0;
        repeat (8) begin
            if (bus.duty_vld === 1'b1) n_vld++;
            @(negedge clk);
        end
        chk("ab_nvld", n_vld, 0);
        chk("ab_duty", bus.mtr_duty, 0);
        chk("ab_rev", bus.rev, 0);
        chk("ab_busy", bus.busy, 0);
        run_sample(16'sd100, "ab_after");
        chk("ab_after_duty", bus.mtr_duty, 1622);

        // Integrator clamps at +131071: I=255 P=382 D=0
        do_reset();
        for (int i = 0; i < 300; i++) run_sample(16'sd600, "clamp");
        chk("clamp_duty", bus.mtr_duty, 1617);
        chk("clamp_rev", bus.rev, 0);

        // Large positive PID saturates duty at 0x7FF
        run_sample(-16'sd600, "neg1");
        run_sample(-16'sd600, "neg2");
        run_sample(16'sd600, "sat");
        chk("sat_duty", bus.mtr_duty, 2047);
        chk("sat_rev", bus.rev, 0);

        // One-cycle rider_off pulse clears integrator and queue
        @(negedge clk);
        bus.rider_off = 1'b1;
        @(negedge clk);
        bus.rider_off = 1'b0;
        run_sample(16'sd100, "ro_pulse");
        chk("ro_pulse_duty", bus.mtr_duty, 1622);

        // rider_off held through a sequence: integrator 0, queue 0
        run_sample(16'sd600, "ro_pre1");
        run_sample(16'sd600, "ro_pre2");
        @(negedge clk);
        bus.rider_off = 1'b1;
        run_sample(16'sd100, "ro_hold");
        chk("ro_hold_duty", bus.mtr_duty, 1622);
        @(negedge clk);
        bus.rider_off = 1'b0;

        // Power down forces zero drive and ignores vld
        run_sample(16'sd600, "pw_pre1");
        run_sample(16'sd600, "pw_pre2");
        @(negedge clk);
        bus.pwr_up = 1'b0;
        @(negedge clk);
        chk("pw_duty", bus.mtr_duty, 0);
        chk("pw_rev", bus.rev, 0);
        bus.vld = 1'b1; bus.ptch = 16'sd100;
        @(negedge clk);
        bus.vld = 1'b0;
        chk("pw_busy", bus.busy, 0);
        chk("pw_drop", bus.drop, 0);
        n_vld = 0;
        repeat (6) begin
            if (bus.duty_vld === 1'b1) n_vld++;
            @(negedge clk);
        end
        chk("pw_nvld", n_vld, 0);
        bus.pwr_up    = 1'b1;
        bus.rider_off = 1'b1;
        @(negedge clk);
        bus.rider_off = 1'b0;
        run_sample(16'sd100, "pw_after");
        chk("pw_after_duty", bus.mtr_duty, 1622);
        chk("pw_after_rev", bus.rev, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
